// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command controller: FSM states, command codes, ALU_FUN groups.
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_GET_FUN,
    S_ALU_RUN,
    S_WAIT_RES,
    S_TX_LO,
    S_TX_HI
  } ctrl_state_e;

  localparam logic [7:0] CMD_LOAD  = 8'hCC;
  localparam logic [7:0] CMD_REUSE = 8'hDD;

  // ALU_FUN[3:2] picks the functional unit inside the ALU.
  typedef enum logic [1:0] {
    FUN_GRP_ARITH = 2'b00,
    FUN_GRP_LOGIC = 2'b01,
    FUN_GRP_CMP   = 2'b10,
    FUN_GRP_SHIFT = 2'b11
  } fun_grp_e;

  function automatic fun_grp_e fun_group(input logic [3:0] fun);
    return fun_grp_e'(fun[3:2]);
  endfunction

endpackage

// File: rtl/alu_res_tx.sv
// Sends the captured result low byte then high byte; registered strobe 1 cycle after TX_BUSY is seen low.
// While busy is high the strobe stays low and the data register holds its last byte.
module alu_res_tx
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  ctrl_state_e               state_i,
  input  logic [2*DATA_WIDTH-1:0]   result_i,
  input  logic                      tx_busy_i,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_vld_o,
  output logic                      byte_sent_o
);

  logic                  tx_lo;
  logic                  tx_hi;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;

  assign tx_lo       = (state_i == S_TX_LO);
  assign tx_hi       = (state_i == S_TX_HI);
  assign byte_sent_o = (tx_lo || tx_hi) && !tx_busy_i;

  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    if (byte_sent_o) begin
      vld_d  = 1'b1;
      data_d = tx_hi ? result_i[2*DATA_WIDTH-1:DATA_WIDTH] : result_i[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign tx_data_o = data_q;
  assign tx_vld_o  = vld_q;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-command front end for an ALU: 0xCC A B FUN or 0xDD FUN, ALU_EN 1 cycle after FUN, result sent as two bytes.
// Optional ALU_CMD_TIMEOUT_EN aborts WAIT_RES after TIMEOUT_CYCLES with a CMD_ERR pulse.
module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   OP_A,
  output logic [DATA_WIDTH-1:0]   OP_B,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    CTRL_BUSY,
  output logic                    CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] LOAD_CODE  = DATA_WIDTH'(CMD_LOAD);
  localparam logic [DATA_WIDTH-1:0] REUSE_CODE = DATA_WIDTH'(CMD_REUSE);

  ctrl_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]     op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]     op_b_q, op_b_d;
  logic [3:0]                fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0]   res_q, res_d;
  logic                      err_q, err_d;
  logic                      byte_sent;
  logic                      timeout;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  // Counter reads 0 on the first WAIT_RES cycle, so the abort lands after exactly TIMEOUT_CYCLES cycles there.
  assign timeout    = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign wait_cnt_d = (state_q == S_WAIT_RES) ? wait_cnt_q + TW'(1) : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    fun_d   = fun_q;
    res_d   = res_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == LOAD_CODE)       state_d = S_GET_A;
          else if (RX_P_DATA == REUSE_CODE) state_d = S_GET_FUN;
          else                              err_d   = 1'b1;
        end
      end
      S_GET_A: begin
        if (RX_D_VLD) begin
          op_a_d  = RX_P_DATA;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (RX_D_VLD) begin
          op_b_d  = RX_P_DATA;
          state_d = S_GET_FUN;
        end
      end
      S_GET_FUN: begin
        if (RX_D_VLD) begin
          fun_d   = RX_P_DATA[3:0];
          state_d = S_ALU_RUN;
        end
      end
      S_ALU_RUN: state_d = S_WAIT_RES;
      S_WAIT_RES: begin
        if (ALU_OUT_VLD) begin
          res_d   = ALU_OUT;
          state_d = S_TX_LO;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TX_LO: if (byte_sent) state_d = S_TX_HI;
      S_TX_HI: if (byte_sent) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      fun_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      fun_q   <= fun_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  alu_res_tx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_res_tx (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .state_i     (state_q),
    .result_i    (res_q),
    .tx_busy_i   (TX_BUSY),
    .tx_data_o   (TX_P_DATA),
    .tx_vld_o    (TX_D_VLD),
    .byte_sent_o (byte_sent)
  );

  assign ALU_FUN   = fun_q;
  assign OP_A      = op_a_q;
  assign OP_B      = op_b_q;
  assign ALU_EN    = (state_q == S_ALU_RUN);
  assign CTRL_BUSY = (state_q != S_IDLE);
  assign CMD_ERR   = err_q;

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, byte width of RX/TX and ALU operands.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 16, max cycles waiting for ALU result (used only with ALU_CMD_TIMEOUT_EN).
REQ-003 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_P_DATA  in  DATA_WIDTH  received command/operand byte.
REQ-006 SHALL have port RX_D_VLD  in  1  RX_P_DATA valid, one-cycle strobe per byte.
REQ-007 SHALL have port ALU_OUT  in  2*DATA_WIDTH  ALU result.
REQ-008 SHALL have port ALU_OUT_VLD  in  1  ALU_OUT valid strobe.
REQ-009 SHALL have port ALU_FUN  out  4  ALU function; bits [3:2] drive the ALU unit decoder selection (00 arith, 01 logic, 10 cmp, 11 shift).
REQ-010 SHALL have port ALU_EN  out  1  one-cycle ALU start pulse.
REQ-011 SHALL have ports OP_A, OP_B  out  DATA_WIDTH each  latched operands.
REQ-012 SHALL have port TX_P_DATA  out  DATA_WIDTH  result byte to transmitter.
REQ-013 SHALL have port TX_D_VLD  out  1  one-cycle strobe, TX_P_DATA valid.
REQ-014 SHALL have port TX_BUSY  in  1  transmitter busy; no TX_D_VLD while high.
REQ-015 SHALL have ports CTRL_BUSY out 1 (state != IDLE) and CMD_ERR out 1 (one-cycle error pulse).

Function
REQ-016 SHALL implement FSM states IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, TX_LO, TX_HI.
REQ-017 IDLE: RX byte 0xCC -> GET_A; 0xDD -> GET_FUN (reuse last OP_A/OP_B); any other byte -> CMD_ERR pulse next cycle, stay IDLE.
REQ-018 GET_A/GET_B/GET_FUN: latch RX_P_DATA into OP_A/OP_B/ALU_FUN (low 4 bits) on RX_D_VLD, advance; wait indefinitely otherwise.
REQ-019 ALU_RUN: ALU_EN high exactly one cycle with OP_A/OP_B/ALU_FUN stable, -> WAIT_RES; ALU_EN low in every other state.
REQ-020 WAIT_RES: capture ALU_OUT on ALU_OUT_VLD, -> TX_LO; ALU_OUT_VLD in any other state ignored.
REQ-021 TX_LO: when TX_BUSY low, TX_D_VLD one cycle with result[7:0], -> TX_HI; TX_HI likewise with result[15:8], -> IDLE.
REQ-022 TX_BUSY high SHALL hold TX state with TX_D_VLD low and TX_P_DATA unchanged.
REQ-023 RX_D_VLD in ALU_RUN, WAIT_RES, TX_LO, TX_HI SHALL be dropped without error.
REQ-024 Latency: ALU_EN rises 1 cycle after the ALU_FUN byte strobe; first TX_D_VLD no earlier than 1 cycle after ALU_OUT_VLD.
REQ-025 Operands SHALL persist across commands until overwritten by a 0xCC frame.

Reset
REQ-026 RST low SHALL immediately force IDLE and zero ALU_FUN, ALU_EN, OP_A, OP_B, TX_P_DATA, TX_D_VLD, CTRL_BUSY, CMD_ERR, result register.
REQ-027 Reset mid-frame or mid-WAIT_RES SHALL abandon the command; a later ALU_OUT_VLD SHALL produce no TX.

Configuration
REQ-028 With ALU_CMD_TIMEOUT_EN defined, WAIT_RES SHALL count cycles; at TIMEOUT_CYCLES without ALU_OUT_VLD, pulse CMD_ERR one cycle, -> IDLE, no TX.
REQ-029 Without ALU_CMD_TIMEOUT_EN, no counter SHALL exist and WAIT_RES waits indefinitely.

Structure
REQ-030 Shared package alu_cmd_pkg SHALL hold state enum, command codes 0xCC/0xDD, ALU_FUN group encodings.
REQ-031 TX byte sequencing (TX_LO/TX_HI, busy hold) SHALL be sub-module alu_res_tx; the rest stays in alu_cmd_ctrl.

Verification
REQ-032 RX 0xCC,0x05,0x03,0x00 -> ALU_EN pulse, OP_A=0x05, OP_B=0x03, ALU_FUN=0x0; ALU_OUT=0x0008 -> TX 0x08 then 0x00.
REQ-033 After REQ-032, RX 0xDD,0x04 -> ALU_EN with OP_A=0x05, OP_B=0x03, ALU_FUN=0x4; ALU_OUT=0x0001 -> TX 0x01, 0x00.
REQ-034 RX 0x7E in IDLE -> CMD_ERR one cycle, CTRL_BUSY stays 0, no ALU_EN.
REQ-035 ALU_OUT=0xA55A with TX_BUSY high 10 cycles -> no TX_D_VLD for 10 cycles, then 0x5A, 0xA5; RX bytes meanwhile ignored.
REQ-036 RST low in WAIT_RES, then ALU_OUT_VLD -> all outputs 0, no TX; with ALU_CMD_TIMEOUT_EN, no ALU_OUT_VLD for 16 cycles -> CMD_ERR, IDLE.
